grid_path_walker: RTL and testbench
===================================

// Module: grid_path_walker
// PURPOSE
//  Consumer of the grid shortest-path solver's result. It takes the unordered path bitmask plus source/destination
//  and replays the path as an ordered, handshaked stream of per-hop moves, one node per transfer.
//  Validates the mask against the blocked-cell map and reports broken or ambiguous paths.
//  Feeds the motion/route controller downstream of the solver.
// PARAMETERS
//  ROWS   3  grid rows; node index = row*COLS + col
//  COLS   3  grid columns
//  N      9  node count, must equal ROWS*COLS (mask width)
//  IDX_W  4  node index width, 2**IDX_W > N
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      synchronous, active-high
//  start         in   1      launch walk; sampled only in IDLE
//  path_in       in   N      path cells (1 = on path), latched on start
//  subset_cells  in   N      usable cells (0 = blocked), latched on start
//  source        in   IDX_W  start node, latched on start
//  destination   in   IDX_W  end node, latched on start
//  busy          out  1      high from the cycle after start until DONE/ERR exit
//  step_valid    out  1      step_node/step_dir valid
//  step_ready    in   1      downstream accepts step
//  step_node     out  IDX_W  node entered by this step
//  step_dir      out  3      0 NONE (first step), 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT
//  hop_count     out  IDX_W  accepted moves excluding first step; held until next start
//  done          out  1      one-cycle pulse: walk completed cleanly
//  error         out  1      one-cycle pulse: walk aborted
//  err_code      out  2      1 bad endpoint, 2 blocked cell on path, 3 discontinuity; held until next start
// BEHAVIOUR
//  Reset: state IDLE; busy, step_valid, done, error = 0; step_node, step_dir, hop_count, err_code = 0.
//   Reset mid-walk aborts immediately. No done/error pulse. Stream drops without completing the pending step.
//  States: IDLE -> CHECK -> WALK -> (DONE | ERR) -> IDLE.
//  IDLE: start=1 latches inputs, clears hop_count/err_code, goes to CHECK. start ignored in all other states.
//  CHECK (1 cycle), priority order:
//   source or destination >= N, or either bit clear in path_in -> ERR code 1.
//   (path_in & ~subset_cells) != 0 -> ERR code 2.
//   else cur=source, remaining=path_in & ~(1<<source), go to WALK with step (source, NONE) presented.
//  First step_valid in cycle t+2 for start sampled at t.
//  WALK handshake: transfer when step_valid && step_ready.
//   While step_valid && !step_ready, step_node/step_dir held stable.
//  On each transfer:
//   If step_node == destination: remaining != 0 -> ERR code 3, else DONE.
//   Else find neighbours of step_node with bit set in remaining: UP idx-COLS (row>0), DOWN idx+COLS (row<ROWS-1),
//   LEFT idx-1 (col>0), RIGHT idx+1 (col<COLS-1). No row wrap-around.
//   Exactly one neighbour -> present it next cycle (back-to-back: step_valid stays high),
//   clear its bit in remaining, hop_count += 1.
//   Zero or more than one -> ERR code 3.
//  hop_count increments when the new hop is presented. After DONE it equals the path length in moves.
//  DONE: done=1, busy=0, step_valid=0 for one cycle, then IDLE.
//  ERR: error=1, busy=0, step_valid=0 for one cycle, then IDLE.
//  source == destination: only valid mask is the single bit. One step (node, NONE), then DONE with hop_count 0.
//   Extra bits in that mask -> ERR code 3 after the step transfers.
//  Empty path_in always fails CHECK with code 1.
// TESTING
//  1. path_in=9'b100100111, subset all 1, src 0, dst 8, ready=1
//     -> steps (0,NONE)(1,RIGHT)(2,RIGHT)(5,DOWN)(8,DOWN) on consecutive cycles, done pulse, hop_count=4.
//  2. Test 1 with step_ready toggling pseudo-randomly
//     -> identical step sequence, outputs stable while stalled, done, hop_count=4.
//  3. subset=9'b111101111, path_in=9'b000010010, src 1, dst 4
//     -> error at t+2, err_code=2, no step_valid.
//  4. path_in=9'b000000011, src 0, dst 8 -> err_code=1.
//     Same with src=9 -> err_code=1.
//  5. path_in=9'b100000001, src 0, dst 8 -> step (0,NONE) then err_code=3.
//     path_in=9'b000011011, src 0, dst 4 -> step (0,NONE) then err_code=3 (branch).
//  6. path_in=9'b000010000, src=dst=4 -> single step (4,NONE), done, hop_count=0.
//     Reset during test-1 WALK -> next cycle all outputs 0, IDLE, no done/error.

Source files
------------

// File: rtl/grid_path_walker.sv
// Replays an unordered grid path bitmask as an ordered, handshaked stream of per-hop moves.
// The mask is validated against the blocked-cell map, and broken or ambiguous paths are reported.
module grid_path_walker #(
   parameter int ROWS  = 3,
   parameter int COLS  = 3,
   parameter int N     = 9,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [N-1:0]     path_in,
   input  logic [N-1:0]     subset_cells,
   input  logic [IDX_W-1:0] source,
   input  logic [IDX_W-1:0] destination,
   output logic             busy,
   output logic             step_valid,
   input  logic             step_ready,
   output logic [IDX_W-1:0] step_node,
   output logic [2:0]       step_dir,
   output logic [IDX_W-1:0] hop_count,
   output logic             done,
   output logic             error,
   output logic [1:0]       err_code
);

   localparam logic [N-1:0]     ONE      = N'(1);
   localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N);
   localparam logic [IDX_W-1:0] COLS_IDX = IDX_W'(COLS);
   localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
   localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);

   typedef enum logic [2:0] {IDLE, CHECK, WALK, DONE_ST, ERR_ST} state_t;

   state_t           state, state_next;
   logic [N-1:0]     path_r, subset_r, remaining;
   logic [IDX_W-1:0] src_r, dst_r;
   logic             endpoint_bad, blocked_bad;
   logic [IDX_W-1:0] cur_row, cur_col;
   logic [IDX_W-1:0] up_idx, down_idx, left_idx, right_idx, nb_idx;
   logic             up_ok, down_ok, left_ok, right_ok;
   logic [2:0]       nb_count, nb_dir;
   logic             take_hop;
   logic [1:0]       fail_code;

   assign endpoint_bad = (src_r >= N_IDX) || (dst_r >= N_IDX) || !path_r[src_r] || !path_r[dst_r];
   assign blocked_bad  = |(path_r & ~subset_r);

   // The row/column guards stop index wrap-around before the remaining-mask lookup matters.
   assign cur_row   = step_node / COLS_IDX;
   assign cur_col   = step_node % COLS_IDX;
   assign up_idx    = step_node - COLS_IDX;
   assign down_idx  = step_node + COLS_IDX;
   assign left_idx  = step_node - IDX_W'(1);
   assign right_idx = step_node + IDX_W'(1);
   assign up_ok     = (cur_row != '0) && remaining[up_idx];
   assign down_ok   = (cur_row != LAST_ROW) && remaining[down_idx];
   assign left_ok   = (cur_col != '0) && remaining[left_idx];
   assign right_ok  = (cur_col != LAST_COL) && remaining[right_idx];
   assign nb_count  = 3'(up_ok) + 3'(down_ok) + 3'(left_ok) + 3'(right_ok);

   always_comb begin
      nb_idx = '0;
      nb_dir = '0;
      if (up_ok) begin
         nb_idx = up_idx;
         nb_dir = 3'd1;
      end
      if (down_ok) begin
         nb_idx = down_idx;
         nb_dir = 3'd2;
      end
      if (left_ok) begin
         nb_idx = left_idx;
         nb_dir = 3'd3;
      end
      if (right_ok) begin
         nb_idx = right_idx;
         nb_dir = 3'd4;
      end
   end

   always_comb begin
      state_next = state;
      fail_code  = '0;
      take_hop   = 1'b0;
      case (state)
         IDLE:  if (start) state_next = CHECK;
         CHECK: begin
            if (endpoint_bad) begin
               state_next = ERR_ST;
               fail_code  = 2'd1;
            end else if (blocked_bad) begin
               state_next = ERR_ST;
               fail_code  = 2'd2;
            end else begin
               state_next = WALK;
            end
         end
         WALK: begin
            if (step_ready) begin
               if (step_node == dst_r) begin
                  state_next = (remaining != '0) ? ERR_ST : DONE_ST;
                  fail_code  = 2'd3;
               end else if (nb_count == 3'd1) begin
                  take_hop = 1'b1;
               end else begin
                  state_next = ERR_ST;
                  fail_code  = 2'd3;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         path_r    <= '0;
         subset_r  <= '0;
         src_r     <= '0;
         dst_r     <= '0;
         remaining <= '0;
         step_node <= '0;
         step_dir  <= '0;
         hop_count <= '0;
         err_code  <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start) begin
                  path_r    <= path_in;
                  subset_r  <= subset_cells;
                  src_r     <= source;
                  dst_r     <= destination;
                  hop_count <= '0;
                  err_code  <= '0;
               end
            end
            CHECK: begin
               if (state_next == WALK) begin
                  step_node <= src_r;
                  step_dir  <= '0;
                  remaining <= path_r & ~(ONE << src_r);
               end
            end
            WALK: begin
               if (take_hop) begin
                  step_node <= nb_idx;
                  step_dir  <= nb_dir;
                  remaining <= remaining & ~(ONE << nb_idx);
                  hop_count <= hop_count + IDX_W'(1);
               end
            end
            default: ;
         endcase
         if (state_next == ERR_ST) err_code <= fail_code;
      end
   end

   assign busy       = (state == CHECK) || (state == WALK);
   assign step_valid = (state == WALK);
   assign done       = (state == DONE_ST);
   assign error      = (state == ERR_ST);

endmodule

// File: tb/tb_grid_path_walker.sv
// Self-checking bench for grid_path_walker: directed table, randomized walks against a path model,
// and hand-written reset / stall sequences.
module tb_grid_path_walker;

   localparam int ROWS = 3;
   localparam int COLS = 3;
   localparam int N    = 9;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [8:0] path_in, subset_cells;
   logic [3:0] source, destination;
   logic       busy, step_valid, step_ready;
   logic [3:0] step_node, hop_count;
   logic [2:0] step_dir;
   logic       done, error;
   logic [1:0] err_code;

   int assert_count = 0;
   int fail_count   = 0;

   int exp_nodes[$];
   int exp_dirs[$];
   int exp_code;
   int exp_hops;

   typedef struct {
      logic [8:0] path;
      logic [8:0] subset;
      int         src;
      int         dst;
      bit         rnd_ready;
      int         code;
      int         hops;
   } vec_t;

   vec_t vecs[10];

   grid_path_walker #(.ROWS(ROWS), .COLS(COLS), .N(N), .IDX_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .path_in(path_in), .subset_cells(subset_cells),
      .source(source), .destination(destination), .busy(busy), .step_valid(step_valid),
      .step_ready(step_ready), .step_node(step_node), .step_dir(step_dir), .hop_count(hop_count),
      .done(done), .error(error), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Path model: walk the grid by coordinates, taking the unique unvisited path neighbour each hop.
   task automatic build_model(input logic [8:0] p, input logic [8:0] s, input int src, input int dst);
      logic [8:0] rem;
      int cur, r, c, cand_n[$], cand_d[$];
      exp_nodes.delete();
      exp_dirs.delete();
      exp_code = 0;
      if (src >= N || dst >= N) exp_code = 1;
      else if (!p[src] || !p[dst]) exp_code = 1;
      else if ((p & ~s) != 0) exp_code = 2;
      if (exp_code != 0) begin
         exp_hops = 0;
         return;
      end
      cur = src;
      rem = p;
      rem[src] = 1'b0;
      exp_nodes.push_back(src);
      exp_dirs.push_back(0);
      forever begin
         if (cur == dst) begin
            exp_code = (rem != 0) ? 3 : 0;
            break;
         end
         r = cur / COLS;
         c = cur % COLS;
         cand_n.delete();
         cand_d.delete();
         if (r > 0 && rem[cur - COLS]) begin cand_n.push_back(cur - COLS); cand_d.push_back(1); end
         if (r < ROWS - 1 && rem[cur + COLS]) begin cand_n.push_back(cur + COLS); cand_d.push_back(2); end
         if (c > 0 && rem[cur - 1]) begin cand_n.push_back(cur - 1); cand_d.push_back(3); end
         if (c < COLS - 1 && rem[cur + 1]) begin cand_n.push_back(cur + 1); cand_d.push_back(4); end
         if (cand_n.size() != 1) begin
            exp_code = 3;
            break;
         end
         cur = cand_n[0];
         rem[cur] = 1'b0;
         exp_nodes.push_back(cur);
         exp_dirs.push_back(cand_d[0]);
      end
      exp_hops = exp_nodes.size() - 1;
   endtask

   task automatic applyStimulus(input logic [8:0] p, input logic [8:0] s, input int src, input int dst,
                                input bit rnd_ready);
      int  idx;
      bit  finished;
      build_model(p, s, src, dst);
      @(negedge clk);
      path_in      = p;
      subset_cells = s;
      source       = 4'(src);
      destination  = 4'(dst);
      start        = 1'b1;
      step_ready   = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_in_check", busy, 1);
      checkOutput("valid_in_check", step_valid, 0);
      idx      = 0;
      finished = 0;
      for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
         @(negedge clk);
         if (cyc == 0) begin
            checkOutput("first_valid", step_valid, (exp_code == 1 || exp_code == 2) ? 0 : 1);
            checkOutput("first_error", error, (exp_code == 1 || exp_code == 2) ? 1 : 0);
         end
         if (step_valid) begin
            if (idx < exp_nodes.size()) begin
               checkOutput($sformatf("step%0d_node", idx), step_node, exp_nodes[idx]);
               checkOutput($sformatf("step%0d_dir", idx), step_dir, exp_dirs[idx]);
            end else begin
               checkOutput("extra_step_index", idx, exp_nodes.size() - 1);
            end
         end
         if (done || error) begin
            finished = 1;
            checkOutput("done_flag", done, exp_code == 0);
            checkOutput("err_code", err_code, exp_code);
            checkOutput("steps_taken", idx, exp_nodes.size());
            checkOutput("hop_count", hop_count, exp_hops);
            checkOutput("busy_at_end", busy, 0);
            checkOutput("valid_at_end", step_valid, 0);
         end else begin
            step_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (step_valid && step_ready) idx++;
         end
      end
      if (!finished) begin
         assert_count++;
         fail_count++;
         $display("[TB] FAIL walk_timeout: got no done/error, expected one within 100 cycles");
      end
      @(negedge clk);
      checkOutput("pulse_one_cycle", done | error, 0);
   endtask

   initial begin
      logic [8:0] p, s, visited;
      int src, dst, cur, len, mode, cand[$];

      reset = 1'b1; start = 1'b0; step_ready = 1'b0;
      path_in = '0; subset_cells = '0; source = '0; destination = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_valid", step_valid, 0);
      checkOutput("reset_done_error", {done, error}, 0);
      checkOutput("reset_regs", {step_node, step_dir, hop_count, err_code}, 0);
      reset = 1'b0;

      vecs[0] = '{9'b100100111, 9'h1FF, 0, 8, 1'b0, 0, 4};
      vecs[1] = '{9'b100100111, 9'h1FF, 0, 8, 1'b1, 0, 4};
      vecs[2] = '{9'b000010010, 9'b111101111, 1, 4, 1'b0, 2, 0};
      vecs[3] = '{9'b000000011, 9'h1FF, 0, 8, 1'b0, 1, 0};
      vecs[4] = '{9'b000000011, 9'h1FF, 9, 1, 1'b0, 1, 0};
      vecs[5] = '{9'b100000001, 9'h1FF, 0, 8, 1'b0, 3, 0};
      vecs[6] = '{9'b000011011, 9'h1FF, 0, 4, 1'b0, 3, 0};
      vecs[7] = '{9'b000010000, 9'h1FF, 4, 4, 1'b0, 0, 0};
      vecs[8] = '{9'b000010010, 9'h1FF, 4, 4, 1'b1, 3, 0};
      vecs[9] = '{9'b100100111, 9'h1FF, 8, 0, 1'b1, 0, 4};

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].path, vecs[i].subset, vecs[i].src, vecs[i].dst, vecs[i].rnd_ready);
         checkOutput($sformatf("table%0d_code", i), err_code, vecs[i].code);
         checkOutput($sformatf("table%0d_hops", i), hop_count, vecs[i].hops);
      end
      checkOutput("empty_path_code", 0, 0 + 0 == 1 ? 1 : 0);
      applyStimulus(9'b0, 9'h1FF, 0, 0, 1'b0);
      checkOutput("empty_path_err", err_code, 1);

      // Reset in the middle of a walk must drop everything without a done/error pulse.
      @(negedge clk);
      path_in = 9'b100100111; subset_cells = 9'h1FF; source = 4'd0; destination = 4'd8;
      start = 1'b1; step_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("mid_walk_valid", step_valid, 1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("mid_reset_flags", {busy, step_valid, done, error}, 0);
      checkOutput("mid_reset_regs", {step_node, step_dir, hop_count, err_code}, 0);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("post_reset_idle", {busy, step_valid, done, error}, 0);
      end

      // Random walks, occasionally corrupted so every error path gets exercised.
      for (int t = 0; t < 40; t++) begin
         src = $urandom_range(0, N - 1);
         visited = '0;
         visited[src] = 1'b1;
         cur = src;
         len = $urandom_range(0, 6);
         for (int h = 0; h < len; h++) begin
            cand.delete();
            if (cur / COLS > 0 && !visited[cur - COLS]) cand.push_back(cur - COLS);
            if (cur / COLS < ROWS - 1 && !visited[cur + COLS]) cand.push_back(cur + COLS);
            if (cur % COLS > 0 && !visited[cur - 1]) cand.push_back(cur - 1);
            if (cur % COLS < COLS - 1 && !visited[cur + 1]) cand.push_back(cur + 1);
            if (cand.size() == 0) break;
            cur = cand[$urandom_range(0, cand.size() - 1)];
            visited[cur] = 1'b1;
         end
         dst = cur;
         p = visited;
         s = 9'h1FF;
         mode = $urandom_range(0, 9);
         if (mode == 0) dst = $urandom_range(0, 15);
         if (mode == 1) s[$urandom_range(0, N - 1)] = 1'b0;
         if (mode == 2) p[$urandom_range(0, N - 1)] = 1'b1;
         applyStimulus(p, s, src, dst, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
